// File: rtl/branch_trace_pkg.sv
// Shared types and defaults for the branch trace replay driver.
package branch_trace_pkg;

    localparam int DEF_DEPTH   = 64;
    localparam int DEF_ADDR_W  = 6;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 255;

    localparam int DIR_BIT  = 8;
    localparam int INST_MSB = 7;
    localparam int REC_W    = DIR_BIT + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_PRED,
        WAIT_TRAIN,
        GAP,
        DONE
    } state_t;

    typedef struct packed {
        logic                dir;
        logic [INST_MSB:0]   inst;
    } rec_t;

    function automatic rec_t to_rec(input logic [REC_W-1:0] raw);
        rec_t r;
        r.dir  = raw[DIR_BIT];
        r.inst = raw[INST_MSB:0];
        return r;
    endfunction

endpackage

// File: rtl/branch_trace_driver_if.sv
// Query/train handshake between the trace driver (master) and the branch predictor (slave).
interface branch_trace_driver_if;
    logic       new_data_avail;
    logic [7:0] inst_lowest_byte;
    logic       direction_ground_truth;
    logic       pred_ready;
    logic       prediction;
    logic       training_done;

    modport master (
        output new_data_avail, inst_lowest_byte, direction_ground_truth,
        input  pred_ready, prediction, training_done
    );

    modport slave (
        input  new_data_avail, inst_lowest_byte, direction_ground_truth,
        output pred_ready, prediction, training_done
    );
endinterface

// File: rtl/branch_trace_mem.sv
// Trace record store: DEPTH x 9 register file.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none; the caller gates writes.
module branch_trace_mem
    import branch_trace_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  rec_t              wdata,
    input  logic [ADDR_W-1:0] raddr,
    output rec_t              rdata
);

    rec_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/branch_trace_driver.sv
// Replays a stored branch trace into the predictor and scores its answers; BRANCH_TRACE_FIRST_MISS_EN adds first-miss capture.
// Latency: >= 4 cycles per record (SETUP, WAIT_PRED, WAIT_TRAIN, GAP), 3 when prediction and training finish together.
// Backpressure: waits on pred_ready / training_done for up to TIMEOUT cycles each, then aborts the replay.
module branch_trace_driver
    import branch_trace_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [REC_W-1:0]         wr_data,
    input  logic [ADDR_W:0]          trace_len,
    input  logic                     start,
    branch_trace_driver_if.master    pred,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err,
    output logic [CNT_W-1:0]         total_cnt,
    output logic [CNT_W-1:0]         correct_cnt,
    output logic                     first_miss_vld,
    output logic [ADDR_W-1:0]        first_miss_idx
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len;
    logic [TO_W-1:0]   to_cnt;
    rec_t              cur_rec;
    rec_t              rd_rec;
    rec_t              load_rec;
    logic [ADDR_W-1:0] rd_addr;

    logic accept;
    logic mem_we;
    logic score;
    logic hit;
    logic to_hit;
    logic abort;
    logic last;

    assign accept = start && (state == IDLE);
    assign mem_we = wr_en && (state == IDLE);
    assign hit    = (pred.prediction == cur_rec.dir);
    assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));
    assign last   = (({1'b0, idx} + (ADDR_W+1)'(1)) == len);

    branch_trace_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (to_rec(wr_data)),
        .raddr (rd_addr),
        .rdata (rd_rec)
    );

    // Data is loaded on entry to SETUP so it is stable a full cycle before
    // new_data_avail rises; a write to address 0 alongside start is forwarded.
    always_comb begin
        rd_addr  = (state == GAP) ? (idx + ADDR_W'(1)) : '0;
        load_rec = rd_rec;
        if (state == IDLE && mem_we && wr_addr == '0) begin
            load_rec = to_rec(wr_data);
        end
    end

    always_comb begin
        state_nxt = state;
        score     = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (trace_len == '0) ? DONE : SETUP;
                end
            end
            SETUP:     state_nxt = WAIT_PRED;
            WAIT_PRED: begin
                if (pred.pred_ready) begin
                    score     = 1'b1;
                    state_nxt = pred.training_done ? GAP : WAIT_TRAIN;
                end else if (to_hit) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end
            end
            WAIT_TRAIN: begin
                if (pred.training_done) begin
                    state_nxt = GAP;
                end else if (to_hit) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end
            end
            GAP:     state_nxt = last ? DONE : SETUP;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            len         <= '0;
            to_cnt      <= '0;
            cur_rec     <= '0;
            total_cnt   <= '0;
            correct_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state) begin
                to_cnt <= '0;
            end else if (to_cnt != '1) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (state_nxt == SETUP) begin
                cur_rec <= load_rec;
            end

            if (accept) begin
                len         <= trace_len;
                idx         <= '0;
                total_cnt   <= '0;
                correct_cnt <= '0;
                timeout_err <= 1'b0;
            end

            if (state == GAP) begin
                idx <= idx + ADDR_W'(1);
            end

            if (score) begin
                if (total_cnt != '1) begin
                    total_cnt <= total_cnt + CNT_W'(1);
                end
                if (hit && correct_cnt != '1) begin
                    correct_cnt <= correct_cnt + CNT_W'(1);
                end
            end

            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef BRANCH_TRACE_FIRST_MISS_EN
    logic              fm_vld_q;
    logic [ADDR_W-1:0] fm_idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fm_vld_q <= 1'b0;
            fm_idx_q <= '0;
        end else if (accept) begin
            fm_vld_q <= 1'b0;
            fm_idx_q <= '0;
        end else if (score && !hit && !fm_vld_q) begin
            fm_vld_q <= 1'b1;
            fm_idx_q <= idx;
        end
    end

    assign first_miss_vld = fm_vld_q;
    assign first_miss_idx = fm_idx_q;
`else
    assign first_miss_vld = 1'b0;
    assign first_miss_idx = '0;
`endif

    assign busy                        = (state != IDLE);
    assign done                        = (state == DONE);
    assign pred.new_data_avail         = (state == WAIT_PRED);
    assign pred.inst_lowest_byte       = cur_rec.inst;
    assign pred.direction_ground_truth = cur_rec.dir;

endmodule

// File: tb/tb_branch_trace_driver.sv
// Scoreboard bench: expected records and end-of-replay summaries are queued at stimulus time, monitors pop on new_data_avail rises and done pulses.
module tb_branch_trace_driver;
    import branch_trace_pkg::*;

`ifdef BRANCH_TRACE_FIRST_MISS_EN
    localparam bit FM_EN = 1'b1;
`else
    localparam bit FM_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] tot;
        logic [15:0] cor;
        logic        tmo;
        logic        fv;
        logic [5:0]  fi;
    } sum_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [8:0]  wr_data;
    logic [6:0]  trace_len;
    logic        start;
    logic        busy, done, timeout_err, first_miss_vld;
    logic [15:0] total_cnt, correct_cnt;
    logic [5:0]  first_miss_idx;

    branch_trace_driver_if pif();

    branch_trace_driver dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .trace_len      (trace_len),
        .start          (start),
        .pred           (pif),
        .busy           (busy),
        .done           (done),
        .timeout_err    (timeout_err),
        .total_cnt      (total_cnt),
        .correct_cnt    (correct_cnt),
        .first_miss_vld (first_miss_vld),
        .first_miss_idx (first_miss_idx)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   mode = 0;
    int   rise_cnt = 0;
    int   done_cnt = 0;
    int   last_rise_cyc = 0;
    int   done_cyc = 0;
    int   gap_ref = -1;
    int   gaps[$];
    logic nda_prev = 1'b0;
    rec_t exp_rec_q[$];
    sum_t exp_done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Predictor model
    initial begin
        pif.pred_ready    = 1'b0;
        pif.prediction    = 1'b0;
        pif.training_done = 1'b0;
        forever begin
            @(negedge clk);
            if (pif.new_data_avail) begin
                if (mode == 0) begin
                    @(negedge clk);
                    @(negedge clk);
                    pif.pred_ready = 1'b1;
                    pif.prediction = 1'b1;
                    @(negedge clk);
                    pif.pred_ready    = 1'b0;
                    pif.training_done = 1'b1;
                    @(negedge clk);
                    pif.training_done = 1'b0;
                end else if (mode == 2) begin
                    pif.pred_ready    = 1'b1;
                    pif.training_done = 1'b1;
                    pif.prediction    = 1'b1;
                    @(negedge clk);
                    pif.pred_ready    = 1'b0;
                    pif.training_done = 1'b0;
                end
            end
        end
    end

    // Monitors
    always @(negedge clk) begin
        if (pif.new_data_avail && !nda_prev) begin
            rise_cnt++;
            if (gap_ref >= 0) gaps.push_back(cyc - gap_ref);
            gap_ref = cyc;
            last_rise_cyc = cyc;
            if (exp_rec_q.size() == 0) begin
                fail("unexpected_record");
            end else begin
                rec_t r;
                r = exp_rec_q.pop_front();
                chk("rec_inst", pif.inst_lowest_byte, r.inst);
                chk("rec_dir", pif.direction_ground_truth, r.dir);
            end
        end
        nda_prev = pif.new_data_avail;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_done_q.size() == 0) begin
                fail("unexpected_done");
            end else begin
                sum_t s;
                s = exp_done_q.pop_front();
                chk("done_total", total_cnt, s.tot);
                chk("done_correct", correct_cnt, s.cor);
                chk("done_timeout_err", timeout_err, s.tmo);
                chk("done_fm_vld", first_miss_vld, s.fv);
                chk("done_fm_idx", first_miss_idx, s.fi);
                chk("done_busy", busy, 1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [8:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [6:0] l);
        trace_len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) return;
            @(negedge clk);
        end
        fail(name);
    endtask

    task automatic wait_rises(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (rise_cnt >= target) return;
            @(negedge clk);
        end
        fail(name);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_nda"}, pif.new_data_avail, 0);
        chk({pfx, "_inst"}, pif.inst_lowest_byte, 0);
        chk({pfx, "_dir"}, pif.direction_ground_truth, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_tmo"}, timeout_err, 0);
        chk({pfx, "_total"}, total_cnt, 0);
        chk({pfx, "_correct"}, correct_cnt, 0);
        chk({pfx, "_fm_vld"}, first_miss_vld, 0);
        chk({pfx, "_fm_idx"}, first_miss_idx, 0);
    endtask

    function automatic sum_t mk_sum(input int tot, input int cor, input bit tmo, input bit miss, input int fi);
        sum_t s;
        s.tot = 16'(tot);
        s.cor = 16'(cor);
        s.tmo = tmo;
        s.fv  = FM_EN & miss;
        s.fi  = (FM_EN & miss) ? 6'(fi) : 6'd0;
        return s;
    endfunction

    // Eight-record trace: inst 0x80+i, taken except records 2 and 5.
    function automatic rec_t rec8(input int i);
        rec_t r;
        r.inst = 8'(8'h80 + i);
        r.dir  = !(i == 2 || i == 5);
        return r;
    endfunction

    initial begin
        int r0, d0, s0, rc;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        trace_len = '0; start = 1'b0;
        tick(3);
        chk_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Four-record replay, always-taken predictor, slow handshake.
        // Record 0 is written in the same cycle as start over a stale value.
        mode = 0;
        wr(6'd0, 9'h1FF);
        wr(6'd1, 9'h022);
        wr(6'd2, 9'h134);
        wr(6'd3, 9'h046);
        exp_rec_q.push_back(rec_t'(9'h110));
        exp_rec_q.push_back(rec_t'(9'h022));
        exp_rec_q.push_back(rec_t'(9'h134));
        exp_rec_q.push_back(rec_t'(9'h046));
        exp_done_q.push_back(mk_sum(4, 2, 0, 1, 1));
        d0 = done_cnt;
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = 9'h110;
        trace_len = 7'd4; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        wait_done(200, "t1_done_wait");
        tick(4);
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_busy_after", busy, 0);

        // Zero-length replay.
        r0 = rise_cnt; d0 = done_cnt;
        exp_done_q.push_back(mk_sum(0, 0, 0, 0, 0));
        s0 = cyc;
        pulse_start(7'd0);
        wait_done(5, "t2_done_wait");
        chk("t2_done_latency_ok", (done_cyc - s0 >= 1) && (done_cyc - s0 <= 2), 1);
        tick(4);
        chk("t2_no_record", rise_cnt - r0, 0);
        chk("t2_done_pulses", done_cnt - d0, 1);

        // Silent predictor: abort after TIMEOUT cycles in WAIT_PRED.
        mode = 1;
        r0 = rise_cnt;
        exp_rec_q.push_back(rec_t'(9'h110));
        exp_done_q.push_back(mk_sum(0, 0, 1, 0, 0));
        pulse_start(7'd2);
        wait_rises(r0 + 1, 10, "t3_rise_wait");
        rc = last_rise_cyc;
        wait_done(300, "t3_done_wait");
        chk("t3_timeout_latency", done_cyc - rc, 255);
        begin
            int hi;
            hi = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (pif.new_data_avail) hi++;
            end
            chk("t3_nda_low_after", hi, 0);
        end
        chk("t3_tmo_sticky", timeout_err, 1);
        chk("t3_records", rise_cnt - r0, 1);

        // Zero-wait predictor over eight records: 3 cycles per record.
        for (int i = 0; i < 8; i++) wr(6'(i), 9'(rec8(i)));
        mode = 2;
        r0 = rise_cnt;
        gaps.delete();
        gap_ref = -1;
        for (int i = 0; i < 8; i++) exp_rec_q.push_back(rec8(i));
        exp_done_q.push_back(mk_sum(8, 6, 0, 1, 2));
        pulse_start(7'd8);
        wait_done(200, "t4_done_wait");
        tick(2);
        chk("t4_records", rise_cnt - r0, 8);
        chk("t4_gap_count", gaps.size(), 7);
        foreach (gaps[i]) chk("t4_cycles_per_record", gaps[i], 3);

        // Reset during the third of eight records; no done may follow.
        mode = 0;
        r0 = rise_cnt; d0 = done_cnt;
        for (int i = 0; i < 8; i++) exp_rec_q.push_back(rec8(i));
        pulse_start(7'd8);
        wait_rises(r0 + 3, 100, "t5_rise_wait");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        rst_n = 1'b1;
        exp_rec_q.delete();
        tick(12);
        chk("t5_no_done", done_cnt - d0, 0);

        // Fresh replay; a write and a start while busy must be ignored.
        r0 = rise_cnt; d0 = done_cnt;
        for (int i = 0; i < 8; i++) exp_rec_q.push_back(rec8(i));
        exp_done_q.push_back(mk_sum(8, 6, 0, 1, 2));
        pulse_start(7'd8);
        wait_rises(r0 + 1, 10, "t6_rise_wait");
        wr(6'd5, 9'h0AA);
        pulse_start(7'd3);
        wait_done(300, "t6_done_wait");
        tick(6);
        chk("t6_done_pulses", done_cnt - d0, 1);
        chk("t6_records", rise_cnt - r0, 8);

        chk("leftover_records", exp_rec_q.size(), 0);
        chk("leftover_summaries", exp_done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish (errors=%0d)", errors);
        $fatal(1);
    end

endmodule
